passcode_programmer: RTL and testbench

Passcode programming block for the lock. It lets the user replace the stored 4-digit switch passcode by entering the new code on `SW`, pressing `btn0` once per digit, and then entering the same code again to confirm. It holds the active code and presents it on `code` to the passcode checker. Programming is allowed only while `prog_en` is high, which the top level drives from the checker's unlocked state.

---
 rtl/passcode_pkg.sv | 28 ++
 rtl/btn_one_shot.sv | 38 +++
 rtl/passcode_programmer.sv | 150 +++++++++++++++
 tb/tb_passcode_programmer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/passcode_pkg.sv
// Shared types and constants for the lock's passcode logic.
// Used by the programmer and the checker.
package passcode_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [DIGIT_W*NUM_DIGITS-1:0] PASSCODE_DEFAULT = 16'h1224;

  typedef enum logic [1:0] {
    sIdle    = 2'd0,
    sNew     = 2'd1,
    sConfirm = 2'd2
  } prog_state_t;

  // MSB-first bar of how many digits the current phase has taken.
  function automatic logic [3:0] led_bar(input logic [1:0] n);
    logic [3:0] bar;
    case (n)
      2'd0:    bar = 4'b0000;
      2'd1:    bar = 4'b1000;
      2'd2:    bar = 4'b1100;
      default: bar = 4'b1110;
    endcase
    return bar;
  endfunction

endpackage

// File: rtl/btn_one_shot.sv
// Active-low button to one-cycle press pulse.
// Two-flop synchronizer followed by a registered rising-edge detect.
module btn_one_shot (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic press_q, press_d;

  always_comb begin
    s1_d    = ~btn_n;
    s2_d    = s1_q;
    s3_d    = s2_q;
    press_d = s2_q & ~s3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/passcode_programmer.sv
// Lets an unlocked user replace the stored passcode.
// New code is entered twice and only committed on a full match.
module passcode_programmer
  import passcode_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE   = PASSCODE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 20 * 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn0,
  input  logic [3:0]  SW,
  input  logic        prog_en,
  output logic [15:0] code,
  output logic        prog_busy,
  output logic        prog_ok,
  output logic        prog_fail,
  output logic [3:0]  led
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic press;

  btn_one_shot u_os (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn0),
    .press (press)
  );

  prog_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shadow_q, shadow_d;
  logic [15:0] code_q, code_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic        ok_q, ok_d;
  logic        fail_q, fail_d;
  logic [3:0]  led_q, led_d;
  logic        last_dig;
  logic        tmr_hit;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    code_d   = code_q;
    ok_d     = 1'b0;
    fail_d   = 1'b0;
    last_dig = (idx_q == 2'd3);
    tmr_hit  = (tmr_q == TMR_LAST);

    unique case (state_q)
      sIdle: begin
        if (press && prog_en) begin
          state_d = sNew;
          idx_d   = 2'd0;
        end
      end
      sNew: begin
        if (!prog_en) begin
          state_d = sIdle;
          idx_d   = 2'd0;
          fail_d  = 1'b1;
        end else if (press) begin
          shadow_d[idx_q] = SW;
          if (last_dig) begin
            state_d = sConfirm;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (tmr_hit) begin
          state_d = sIdle;
          idx_d   = 2'd0;
          fail_d  = 1'b1;
        end
      end
      sConfirm: begin
        if (!prog_en) begin
          state_d = sIdle;
          idx_d   = 2'd0;
          fail_d  = 1'b1;
        end else if (press) begin
          if (SW != shadow_q[idx_q]) begin
            state_d = sIdle;
            idx_d   = 2'd0;
            fail_d  = 1'b1;
          end else if (last_dig) begin
            state_d = sIdle;
            idx_d   = 2'd0;
            ok_d    = 1'b1;
            code_d  = {shadow_q[0], shadow_q[1],
                       shadow_q[2], shadow_q[3]};
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (tmr_hit) begin
          state_d = sIdle;
          idx_d   = 2'd0;
          fail_d  = 1'b1;
        end
      end
      default: begin
        state_d = sIdle;
        idx_d   = 2'd0;
      end
    endcase

    // Counter only runs while a sequence waits on the user.
    if (press || (state_d != state_q) || (state_q == sIdle)) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TMR_ONE;
    end

    led_d = (state_d == sIdle) ? 4'b0000 : led_bar(idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= sIdle;
      idx_q    <= 2'd0;
      shadow_q <= '0;
      code_q   <= DEFAULT_CODE;
      tmr_q    <= '0;
      ok_q     <= 1'b0;
      fail_q   <= 1'b0;
      led_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
      tmr_q    <= tmr_d;
      ok_q     <= ok_d;
      fail_q   <= fail_d;
      led_q    <= led_d;
    end
  end

  assign code      = code_q;
  assign prog_busy = (state_q != sIdle);
  assign prog_ok   = ok_q;
  assign prog_fail = fail_q;
  assign led       = led_q;

endmodule

// File: tb/tb_passcode_programmer.sv
// Directed plus randomized bench for passcode_programmer.
// Expected values come from a queue-based model of the user protocol.
module tb_passcode_programmer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn0;
  logic [3:0]  SW;
  logic        prog_en;
  logic [15:0] code;
  logic        prog_busy;
  logic        prog_ok;
  logic        prog_fail;
  logic [3:0]  led;

  int checks = 0;
  int failures = 0;
  int press_cnt = 0;

  passcode_programmer #(
    .DEFAULT_CODE   (16'h1224),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn0      (btn0),
    .SW        (SW),
    .prog_en   (prog_en),
    .code      (code),
    .prog_busy (prog_busy),
    .prog_ok   (prog_ok),
    .prog_fail (prog_fail),
    .led       (led)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (dut.u_os.press === 1'b1) press_cnt++;

  // model: 0 idle, 1 entering, 2 confirming
  int         m_mode = 0;
  logic [3:0] m_ent[$];
  int         m_match = 0;
  logic [15:0] m_code = 16'h1224;
  logic       e_ok = 1'b0;
  logic       e_fail = 1'b0;

  function automatic void m_reset();
    m_mode = 0; m_ent.delete(); m_match = 0;
    m_code = 16'h1224; e_ok = 1'b0; e_fail = 1'b0;
  endfunction

  function automatic void m_abort();
    e_ok = 1'b0; e_fail = (m_mode != 0); m_mode = 0;
  endfunction

  function automatic void m_press(input logic [3:0] sw, input logic en);
    e_ok = 1'b0; e_fail = 1'b0;
    if (m_mode != 0 && !en) begin
      e_fail = 1'b1; m_mode = 0; return;
    end
    case (m_mode)
      0: if (en) begin m_mode = 1; m_ent.delete(); end
      1: begin
        m_ent.push_back(sw);
        if (m_ent.size() == 4) begin m_mode = 2; m_match = 0; end
      end
      default: begin
        if (sw == m_ent[m_match]) begin
          m_match++;
          if (m_match == 4) begin
            m_code = {m_ent[0], m_ent[1], m_ent[2], m_ent[3]};
            e_ok = 1'b1; m_mode = 0;
          end
        end else begin
          e_fail = 1'b1; m_mode = 0;
        end
      end
    endcase
  endfunction

  function automatic logic [3:0] m_led();
    logic [3:0] ones = 4'hF;
    int n;
    n = (m_mode == 1) ? m_ent.size() : (m_mode == 2) ? m_match : 0;
    return ~(ones >> n);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".code"}, code, m_code);
    chk({tag, ".busy"}, 16'(prog_busy), 16'(m_mode != 0));
    chk({tag, ".led"},  16'(led), 16'(m_led()));
    chk({tag, ".ok"},   16'(prog_ok), 16'(e_ok));
    chk({tag, ".fail"}, 16'(prog_fail), 16'(e_fail));
  endtask

  // Falls after a posedge, decides at the 4th edge, checks the pulse width.
  task automatic press(input string tag, input logic [3:0] sw, input int gap);
    repeat (gap) @(posedge clk);
    #1 SW = sw; btn0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 m_press(sw, prog_en);
    chk_all(tag);
    btn0 = 1'b1;
    @(posedge clk);
    #1 e_ok = 1'b0; e_fail = 1'b0;
    chk_all({tag, ".after"});
  endtask

  task automatic enter4(input string tag, input logic [15:0] c);
    for (int i = 0; i < 4; i++) press(tag, c[15-4*i -: 4], 3);
  endtask

  initial begin
    logic [15:0] rc, cc;
    int p0, bad;
    rst_n = 1'b0; btn0 = 1'b1; SW = 4'h0; prog_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_all("reset");
    rst_n = 1'b1;
    press("en_low", 4'h7, 2);

    prog_en = 1'b1;
    press("mm_start", 4'h0, 3);
    enter4("mm_new", 16'h3579);
    press("mm_c0", 4'h3, 3);
    press("mm_c1", 4'h5, 3);
    press("mm_c2", 4'h6, 3);

    press("good_start", 4'hF, 3);
    enter4("good_new", 16'h3579);
    enter4("good_conf", 16'h3579);

    // timeout: nothing after 2 digits
    press("to_start", 4'h0, 3);
    press("to_d0", 4'h1, 3);
    press("to_d1", 4'h2, 3);
    bad = 0;
    for (int i = 2; i < 100; i++) begin
      @(posedge clk);
      #1 if (prog_fail !== 1'b0) bad++;
    end
    chk("to_early", 16'(bad), 16'd0);
    @(posedge clk);
    #1 m_abort();
    chk_all("to_hit");
    @(posedge clk);
    #1 e_fail = 1'b0;
    chk_all("to_after");

    // press landing on the terminal count wins
    press("tl_start", 4'h0, 3);
    press("tl_d0", 4'h1, 3);
    press("tl_d1", 4'h2, 3);
    press("tl_d2", 4'h3, 95);
    press("tl_d3", 4'h4, 3);

    // abort in confirm
    press("ab_c0", 4'h1, 3);
    @(posedge clk);
    #1 prog_en = 1'b0;
    @(posedge clk);
    #1 m_abort();
    chk_all("abort");
    prog_en = 1'b1;

    for (int r = 0; r < 6; r++) begin
      rc = 16'($urandom);
      cc = rc;
      if ($urandom_range(0, 1) == 1) begin
        bad = $urandom_range(0, 3);
        cc[15-4*bad -: 4] = rc[15-4*bad -: 4] + 4'($urandom_range(1, 15));
      end
      press("rnd_start", 4'($urandom), 3);
      enter4("rnd_new", rc);
      for (int i = 0; i < 4 && m_mode == 2; i++)
        press("rnd_conf", cc[15-4*i -: 4], 3);
    end

    // long hold with programming locked out
    prog_en = 1'b0;
    p0 = press_cnt;
    @(posedge clk);
    #1 btn0 = 1'b0;
    repeat (1000) @(posedge clk);
    #1 btn0 = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("hold_cnt", 16'(press_cnt - p0), 16'd1);
    chk_all("hold");

    // glitch between edges is invisible
    p0 = press_cnt;
    prog_en = 1'b1;
    @(posedge clk);
    #2 btn0 = 1'b0;
    #3 btn0 = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("glitch_miss", 16'(press_cnt - p0), 16'd1 - 16'd1);
    chk_all("glitch_miss");

    // glitch spanning one edge is a single press
    @(posedge clk);
    #1 btn0 = 1'b0;
    @(posedge clk);
    #1 btn0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 m_press(4'h0, 1'b1);
    chk("glitch_hit", 16'(press_cnt - p0), 16'd1);
    chk_all("glitch_hit");

    // reset in the middle of entry
    press("rs_d0", 4'h9, 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 m_reset();
    chk_all("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
